mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Drives the integer MAC PE (registered c_ab = a*b + c, 1-cycle latency) to compute dot products.
//  - Accepts a job: length, bias. Then accepts len operand pairs over a valid/ready stream.
//  - Issues one pair per cycle to the PE, feeding c_ab back as the next c.
//  - Returns the final accumulation on a valid/ready result port.
//  Sits between the operand buffers and one PE instance. Mirrors the PE: it feeds the PE and reads it back.
// PARAMETERS
//  REG_WIDTH  16  operand/accumulator width; must equal the PE REG_WIDTH
//  LEN_WIDTH  8   width of job length; max job = 2^LEN_WIDTH-1 pairs
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          job request; accepted only when busy==0
//  len        in   LEN_WIDTH  number of operand pairs in the job, sampled with start
//  bias       in   REG_WIDTH  initial accumulator value, sampled with start
//  busy       out  1          high in every state except IDLE
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          high only in RUN
//  in_a       in   REG_WIDTH  operand a
//  in_b       in   REG_WIDTH  operand b
//  pe_a_n_1   out  REG_WIDTH  to PE a_n_1 (registered)
//  pe_b_n_1   out  REG_WIDTH  to PE b_n_1 (registered)
//  pe_c_n_1   out  REG_WIDTH  to PE c_n_1 (combinational mux, see below)
//  pe_c_ab    in   REG_WIDTH  from PE c_ab
//  res_valid  out  1          result available
//  res_ready  in   1          result consumed when res_valid & res_ready
//  res_data   out  REG_WIDTH  dot-product result, low REG_WIDTH bits
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - State = IDLE. pe_a/pe_b = 0. first_q = 0. res_valid = 0. res_data = 0. count = 0.
//  - Outputs: busy = 0, in_ready = 0, pe_c = 0.
//  - Reset mid-job abandons the job. No result is produced.
//  FSM: IDLE -> RUN -> FLUSH -> CAPT -> DONE -> IDLE
//  - IDLE:  start=1 latches len, bias; count = 0; first_q = 1.
//           Next state is RUN, or FLUSH if len==0.
//  - RUN:   on in_valid&in_ready: pe_a<=in_a, pe_b<=in_b, count++.
//           Leaves to FLUSH on the handshake with count==len-1.
//  - Bubble (RUN, in_valid=0): pe_a<=0, pe_b<=0, so the PE holds c_ab = 0*0 + c_ab.
//  - FLUSH: the last issued beat is on the PE inputs.
//           For a len==0 job, the beat is pe_a=pe_b=0 with first_q=1, so result = bias.
//  - CAPT:  pe_a=pe_b=0. Capture res_data <= pe_c_ab; res_valid <= 1.
//  - DONE:  hold res_data, res_valid until res_ready. The handshake clears res_valid and returns to IDLE.
//  pe_c_n_1 mux:
//  - IDLE: 0.
//  - Beat on PE inputs is element 0 (first_q=1): bias_q.
//  - Otherwise: pe_c_ab.
//  - first_q clears after the first issued beat.
//  Latency: last input handshake in cycle t -> res_valid high in cycle t+3.
//  Throughput: one pair/cycle with no bubbles; bubbles insert cycles with no change to the result.
//  Arithmetic: same as the PE, wraps modulo 2^REG_WIDTH. No saturation, no overflow flag.
//  Simultaneous events:
//  - start while busy: ignored, not queued.
//  - DONE handshake and start in the same cycle: start ignored. A new job may start the cycle after IDLE is re-entered.
//  - in_valid outside RUN: ignored (in_ready=0).
//  - len/bias changes after the start handshake have no effect on the current job.
// STRUCTURE
//  - mac_pkg holds: state_t enum {IDLE,RUN,FLUSH,CAPT,DONE} and the REG_WIDTH/LEN_WIDTH defaults.
//  - Single module. No sub-module is natural; the PE is instantiated alongside, at the level above.
// TESTING (bench instantiates this block + integer MAC PE, REG_WIDTH=16)
//  1. len=4, bias=10, a={1,2,3,4}, b={5,6,7,8} back-to-back, res_ready=1
//     -> res_data=80; res_valid in cycle t+3 of the last handshake.
//  2. Same job with in_valid low for 3 cycles between pairs 2 and 3 -> res_data=80; PE c_ab stable during bubbles.
//  3. len=0, bias=7 -> no in_ready pulse, res_data=7.
//  4. len=2, bias=1, a={0xFFFF,2}, b={0xFFFF,3} -> res_data=0x0008 (wrap).
//  5. res_ready low 5 cycles after res_valid -> res_data stable, busy=1; start ignored; IDLE after the handshake.
//  6. rst_n pulsed low mid-RUN (pair 2 of 4) -> all outputs at reset values immediately.
//     A fresh job (test 1) then yields 80.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default sizes for the MAC dot-product sequencer.
package mac_pkg;

    localparam int DEF_REG_WIDTH = 16;
    localparam int DEF_LEN_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Streams operand pairs into one registered MAC PE, feeds its c_ab output back
// as the next c, and returns the final accumulation on a valid/ready port.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [REG_WIDTH-1:0] bias,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_WIDTH-1:0] in_a,
    input  logic [REG_WIDTH-1:0] in_b,
    output logic [REG_WIDTH-1:0] pe_a_n_1,
    output logic [REG_WIDTH-1:0] pe_b_n_1,
    output logic [REG_WIDTH-1:0] pe_c_n_1,
    input  logic [REG_WIDTH-1:0] pe_c_ab,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [REG_WIDTH-1:0] res_data
);

    state_t                 state;
    state_t                 state_next;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [REG_WIDTH-1:0]   bias_q;
    logic [LEN_WIDTH-1:0]   count;
    logic                   first_q;
    logic                   beat_q;
    logic                   in_fire;
    logic                   last_beat;

    assign in_fire   = in_valid && (state == RUN);
    assign last_beat = (count == len_q - LEN_WIDTH'(1));

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured from IDLE, so it is never queued.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = (len == '0) ? FLUSH : RUN;
            RUN:   if (in_fire && last_beat) state_next = FLUSH;
            FLUSH: state_next = CAPT;
            CAPT:  state_next = DONE;
            DONE:  if (res_valid && res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs and the PE c-input mux (bias for element 0, feedback otherwise).
    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == RUN);
        if (state == IDLE) begin
            pe_c_n_1 = '0;
        end else if (first_q) begin
            pe_c_n_1 = bias_q;
        end else begin
            pe_c_n_1 = pe_c_ab;
        end
    end

    // Job registers and PE operand issue; bubbles drive zeros so the PE holds its sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            bias_q   <= '0;
            count    <= '0;
            first_q  <= 1'b0;
            beat_q   <= 1'b0;
            pe_a_n_1 <= '0;
            pe_b_n_1 <= '0;
        end else begin
            if (first_q && beat_q) begin
                first_q <= 1'b0;
            end
            pe_a_n_1 <= '0;
            pe_b_n_1 <= '0;
            beat_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        bias_q  <= bias;
                        count   <= '0;
                        first_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        pe_a_n_1 <= in_a;
                        pe_b_n_1 <= in_b;
                        beat_q   <= 1'b1;
                        count    <= count + LEN_WIDTH'(1);
                    end
                end
                CAPT: begin
                    first_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Result register: capture the PE output after the last beat, hold until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (state == CAPT) begin
                res_data  <= pe_c_ab;
                res_valid <= 1'b1;
            end else if (state == DONE && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer with a behavioural MAC PE alongside.
module tb_mac_dot_sequencer;
    import mac_pkg::*;

    localparam int RW = 16;
    localparam int LW = 8;

    typedef logic [15:0][RW-1:0] vec_t;

    typedef struct {
        int          n;
        logic [RW-1:0] bias;
        vec_t        a;
        vec_t        b;
        int          bub_at;
        int          bub_n;
        int          ready_delay;
        logic [RW-1:0] expect_res;
    } vector_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic [RW-1:0] bias;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_a;
    logic [RW-1:0] in_b;
    logic [RW-1:0] pe_a;
    logic [RW-1:0] pe_b;
    logic [RW-1:0] pe_c;
    logic [RW-1:0] pe_c_ab;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    vector_t vecs[4];

    mac_dot_sequencer #(.REG_WIDTH(RW), .LEN_WIDTH(LW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .len(len),
        .bias(bias),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .pe_a_n_1(pe_a),
        .pe_b_n_1(pe_b),
        .pe_c_n_1(pe_c),
        .pe_c_ab(pe_c_ab),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Integer MAC PE: registered c_ab = a*b + c, wrapping at RW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_c_ab <= '0;
        else        pe_c_ab <= pe_a * pe_b + pe_c;
    end

    // Reference: bias plus the sum of products, truncated to RW bits.
    function automatic logic [RW-1:0] dotModel(input int n, input logic [RW-1:0] b0,
                                                input vec_t a, input vec_t b);
        logic [31:0] acc;
        acc = 32'(b0);
        for (int i = 0; i < n; i++) acc = acc + 32'(a[i]) * 32'(b[i]);
        return acc[RW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int n, input logic [RW-1:0] bias_in,
                                 input vec_t a, input vec_t b,
                                 input int bub_at, input int bub_n, input int rand_pct,
                                 input int ready_delay, input bit hold_start,
                                 output logic [RW-1:0] result, output int latency);
        int i;
        int guard;
        int last_hs;
        int bub_left;
        bit hs;
        bit hs_m1;
        bit hs_m2;
        bit seen_ready;
        logic [RW-1:0] c_prev;
        logic [RW-1:0] held;

        @(negedge clk);
        checkOutput("idle_before_start", 32'(busy), 32'd0);
        start   = 1'b1;
        len     = n[LW-1:0];
        bias    = bias_in;
        last_hs = cyc;
        @(negedge clk);
        start = 1'b0;
        len   = LW'($urandom);
        bias  = RW'($urandom);

        i = 0; guard = 0; hs_m1 = 0; hs_m2 = 0; seen_ready = 0;
        bub_left = bub_n; c_prev = pe_c_ab;
        while (i < n && guard < 2000) begin
            if (i >= 1 && !hs_m1 && !hs_m2) checkOutput("bubble_hold", 32'(pe_c_ab), 32'(c_prev));
            c_prev = pe_c_ab;
            if (i == bub_at && bub_left > 0) begin
                in_valid = 1'b0;
                bub_left--;
            end else if ($urandom_range(99) < rand_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
            end
            in_a = a[i];
            in_b = b[i];
            hs = in_valid && in_ready;
            if (hs) begin
                last_hs = cyc;
                i++;
            end
            hs_m2 = hs_m1;
            hs_m1 = hs;
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (i != n) checkOutput("run_timeout", 32'(i), 32'(n));

        guard = 0;
        while (!res_valid && guard < 50) begin
            if (in_ready) seen_ready = 1;
            @(negedge clk);
            guard++;
        end
        if (!res_valid) checkOutput("res_valid_timeout", 32'(res_valid), 32'd1);
        latency = cyc - last_hs;
        if (n == 0) checkOutput("len0_no_in_ready", 32'(seen_ready), 32'd0);

        held = res_data;
        for (int k = 0; k < ready_delay; k++) begin
            res_ready = 1'b0;
            if (hold_start) begin
                start = 1'b1;
                len   = 8'd3;
                bias  = 16'd99;
            end
            @(negedge clk);
            checkOutput("hold_data", 32'(res_data), 32'(held));
            checkOutput("hold_busy", 32'(busy), 32'd1);
            checkOutput("hold_valid", 32'(res_valid), 32'd1);
        end
        res_ready = 1'b1;
        result = res_data;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        checkOutput("idle_after_handshake", 32'(busy), 32'd0);
        checkOutput("valid_cleared", 32'(res_valid), 32'd0);
        if (hold_start) begin
            @(negedge clk);
            checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        checkOutput({tag, "_res_data"}, 32'(res_data), 32'd0);
        checkOutput({tag, "_pe_a"}, 32'(pe_a), 32'd0);
        checkOutput({tag, "_pe_b"}, 32'(pe_b), 32'd0);
        checkOutput({tag, "_pe_c"}, 32'(pe_c), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [RW-1:0] result;
        int            latency;
        vec_t          ra;
        vec_t          rb;
        int            rn;
        logic [RW-1:0] rbias;

        rst_n = 1'b0; start = 1'b0; len = '0; bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;

        vecs[0] = '{n: 4, bias: 16'd10, a: '0, b: '0, bub_at: -1, bub_n: 0, ready_delay: 0, expect_res: 16'd80};
        vecs[0].a[0] = 16'd1; vecs[0].a[1] = 16'd2; vecs[0].a[2] = 16'd3; vecs[0].a[3] = 16'd4;
        vecs[0].b[0] = 16'd5; vecs[0].b[1] = 16'd6; vecs[0].b[2] = 16'd7; vecs[0].b[3] = 16'd8;
        vecs[1] = vecs[0];
        vecs[1].bub_at = 2; vecs[1].bub_n = 3;
        vecs[2] = '{n: 0, bias: 16'd7, a: '0, b: '0, bub_at: -1, bub_n: 0, ready_delay: 0, expect_res: 16'd7};
        vecs[3] = '{n: 2, bias: 16'd1, a: '0, b: '0, bub_at: -1, bub_n: 0, ready_delay: 0, expect_res: 16'h0008};
        vecs[3].a[0] = 16'hFFFF; vecs[3].a[1] = 16'd2;
        vecs[3].b[0] = 16'hFFFF; vecs[3].b[1] = 16'd3;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].n, vecs[v].bias, vecs[v].a, vecs[v].b, vecs[v].bub_at,
                          vecs[v].bub_n, 0, vecs[v].ready_delay, 1'b0, result, latency);
            checkOutput($sformatf("vec%0d_result", v), 32'(result), 32'(vecs[v].expect_res));
            checkOutput($sformatf("vec%0d_latency", v), 32'(latency), 32'd3);
        end

        $display("[TB] result back-pressure with start held");
        applyStimulus(vecs[0].n, vecs[0].bias, vecs[0].a, vecs[0].b, -1, 0, 0, 5, 1'b1,
                      result, latency);
        checkOutput("backpressure_result", 32'(result), 32'd80);

        $display("[TB] reset mid-run");
        @(negedge clk);
        start = 1'b1; len = 8'd4; bias = 16'd10;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 16'd1; in_b = 16'd5;
        @(negedge clk);
        in_a = 16'd2; in_b = 16'd6;
        #2 rst_n = 1'b0;
        #1 checkResetState("midrun_reset");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        applyStimulus(vecs[0].n, vecs[0].bias, vecs[0].a, vecs[0].b, -1, 0, 0, 0, 1'b0,
                      result, latency);
        checkOutput("after_reset_result", 32'(result), 32'd80);

        $display("[TB] random jobs");
        for (int j = 0; j < 25; j++) begin
            rn    = int'($urandom_range(12, 0));
            rbias = RW'($urandom);
            for (int k = 0; k < 16; k++) begin
                ra[k] = RW'($urandom);
                rb[k] = RW'($urandom);
            end
            applyStimulus(rn, rbias, ra, rb, -1, 0, 25, int'($urandom_range(3, 0)), 1'b0,
                          result, latency);
            checkOutput($sformatf("rand%0d_result", j), 32'(result), 32'(dotModel(rn, rbias, ra, rb)));
            checkOutput($sformatf("rand%0d_latency", j), 32'(latency), 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
